// File: rtl/alpha68k_bus_pkg.sv
// alpha68k_bus_pkg: shared rw-mode codes, decoder FSM states and default Alpha68k map
package alpha68k_bus_pkg;

    localparam logic [1:0] RW_ANY = 2'b00;
    localparam logic [1:0] RW_RD  = 2'b01;
    localparam logic [1:0] RW_WR  = 2'b10;
    localparam logic [1:0] RW_OFF = 2'b11;

    typedef enum logic [2:0] {IDLE, DECODE, WAIT, TOUT, ACK, BERR} state_t;

    localparam logic [23:0] ALPHA_ROM_BASE = 24'h000000;
    localparam logic [23:0] ALPHA_ROM_MASK = 24'hFC0000;
    localparam logic [23:0] ALPHA_RAM_BASE = 24'h040000;
    localparam logic [23:0] ALPHA_RAM_MASK = 24'hFFC000;
    localparam logic [23:0] ALPHA_IO_BASE  = 24'h080000;
    localparam logic [23:0] ALPHA_IO_MASK  = 24'hFFFFFE;

    function automatic logic rw_ok(input logic [1:0] mode, input logic rw);
        return (mode == RW_ANY) || (mode == RW_RD && rw) || (mode == RW_WR && !rw);
    endfunction

endpackage

// File: rtl/m68k_region_decoder_if.sv
// m68k_region_decoder_if: config port, 68000 bus inputs and decoder outputs
interface m68k_region_decoder_if #(
    parameter int ADDR_W      = 24,
    parameter int NUM_REGIONS = 16,
    parameter int WAIT_W      = 4,
    parameter int IDX_W       = $clog2(NUM_REGIONS)
);
    logic                   cfg_we;
    logic [IDX_W-1:0]       cfg_idx;
    logic [ADDR_W-1:0]      cfg_base;
    logic [ADDR_W-1:0]      cfg_mask;
    logic [WAIT_W-1:0]      cfg_wait;
    logic [1:0]             cfg_rw_mode;
    logic [ADDR_W-1:0]      m68k_a;
    logic                   m68k_as_n;
    logic                   m68k_rw;
    logic [NUM_REGIONS-1:0] cs;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   dtack_n;
    logic                   berr_n;
    logic                   busy;

    modport master (
        output cfg_we, cfg_idx, cfg_base, cfg_mask, cfg_wait, cfg_rw_mode,
        output m68k_a, m68k_as_n, m68k_rw,
        input  cs, hit, hit_idx, dtack_n, berr_n, busy
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_base, cfg_mask, cfg_wait, cfg_rw_mode,
        input  m68k_a, m68k_as_n, m68k_rw,
        output cs, hit, hit_idx, dtack_n, berr_n, busy
    );
endinterface

// File: rtl/region_table.sv
// region_table: loader-written base/mask windows with parallel match and lowest-index priority
module region_table
    import alpha68k_bus_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int NUM_REGIONS = 16,
    parameter int WAIT_W      = 4,
    parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [ADDR_W-1:0]      cfg_base,
    input  logic [ADDR_W-1:0]      cfg_mask,
    input  logic [WAIT_W-1:0]      cfg_wait,
    input  logic [1:0]             cfg_rw_mode,
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   rw,
    output logic [NUM_REGIONS-1:0] match_vec,
    output logic                   hit,
    output logic [IDX_W-1:0]       idx,
    output logic [WAIT_W-1:0]      wait_cnt
);
    logic [ADDR_W-1:0] base [NUM_REGIONS];
    logic [ADDR_W-1:0] mask [NUM_REGIONS];
    logic [WAIT_W-1:0] wt   [NUM_REGIONS];
    logic [1:0]        mode [NUM_REGIONS];

    // Table entries come up disabled and are rewritten one per cycle by the loader
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base[i] <= '0;
                mask[i] <= '0;
                wt[i]   <= '0;
                mode[i] <= RW_OFF;
            end
        end else if (cfg_we) begin
            base[cfg_idx] <= cfg_base;
            mask[cfg_idx] <= cfg_mask;
            wt[cfg_idx]   <= cfg_wait;
            mode[cfg_idx] <= cfg_rw_mode;
        end

    // Every window compares in parallel against the live address and direction
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            match_vec[i] = rw_ok(mode[i], rw) && (((addr ^ base[i]) & mask[i]) == '0);
    end

    // Scan from the top so the lowest matching index is the one left standing
    always_comb begin
        idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--)
            if (match_vec[i]) idx = IDX_W'(i);
    end

    assign hit      = |match_vec;
    assign wait_cnt = wt[idx];
endmodule

// File: rtl/m68k_region_decoder.sv
// m68k_region_decoder: registered chip selects, DTACK wait states and BERR timeout for the 68000 bus
module m68k_region_decoder
    import alpha68k_bus_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int NUM_REGIONS = 16,
    parameter int WAIT_W      = 4,
    parameter int TIMEOUT     = 64,
    parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
    input logic               clk,
    input logic               reset_n,
    m68k_region_decoder_if.slave bus
);
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > WAIT_W) ? $clog2(TIMEOUT + 1) : WAIT_W;

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_REGIONS-1:0] match_vec, cs_q;
    logic                   t_hit, hit_q;
    logic [IDX_W-1:0]       t_idx, idx_q;
    logic [WAIT_W-1:0]      t_wait;

    region_table #(
        .ADDR_W(ADDR_W), .NUM_REGIONS(NUM_REGIONS), .WAIT_W(WAIT_W), .IDX_W(IDX_W)
    ) u_table (
        .clk(clk), .reset_n(reset_n),
        .cfg_we(bus.cfg_we), .cfg_idx(bus.cfg_idx), .cfg_base(bus.cfg_base),
        .cfg_mask(bus.cfg_mask), .cfg_wait(bus.cfg_wait), .cfg_rw_mode(bus.cfg_rw_mode),
        .addr(bus.m68k_a), .rw(bus.m68k_rw),
        .match_vec(match_vec), .hit(t_hit), .idx(t_idx), .wait_cnt(t_wait)
    );

    // Bus cycle state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    // Strobe release always returns to IDLE; otherwise walk decode, wait/timeout, terminate
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = bus.m68k_as_n ? IDLE : DECODE;
        else if (bus.m68k_as_n)
            state_nx = IDLE;
        else
            case (state)
                DECODE:  state_nx = !t_hit ? TOUT : (t_wait == '0 ? ACK : WAIT);
                WAIT:    state_nx = (cnt == CNT_W'(1)) ? ACK : WAIT;
                TOUT:    state_nx = (cnt == CNT_W'(1)) ? BERR : TOUT;
                default: state_nx = state;
            endcase
    end

    // Latch the decode once per cycle so later table writes and address changes are ignored
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cs_q  <= '0;
            hit_q <= 1'b0;
            idx_q <= '0;
            cnt   <= '0;
        end else if (bus.m68k_as_n) begin
            cs_q  <= '0;
            hit_q <= 1'b0;
            idx_q <= '0;
        end else if (state == DECODE) begin
            cs_q  <= match_vec & (~match_vec + NUM_REGIONS'(1));
            hit_q <= t_hit;
            idx_q <= t_idx;
            cnt   <= t_hit ? CNT_W'(t_wait) : CNT_W'(TIMEOUT);
        end else if (state == WAIT || state == TOUT)
            cnt <= cnt - CNT_W'(1);

    // Handshake outputs come straight off the state register, so they are glitch-free and exclusive
    always_comb begin
        bus.dtack_n = state != ACK;
        bus.berr_n  = state != BERR;
        bus.busy    = state != IDLE;
    end

    assign bus.cs      = cs_q;
    assign bus.hit     = hit_q;
    assign bus.hit_idx = idx_q;
endmodule

// File: doc/m68k_region_decoder.md
# m68k_region_decoder

Runtime-programmable, parametrised successor to the per-PCB 68000 chip-select decoder. It replaces hard-coded `case (pcb)` address maps with a table of `NUM_REGIONS` base/mask windows that the loader writes at boot. It registers a one-hot chip select and generates DTACK, with per-region wait states and a bus-error timeout for unmapped accesses. It sits between the 68000 bus and all main-CPU memory and I/O selects.

## Interface
Parameters:
- `ADDR_W`, 24, CPU address width
- `NUM_REGIONS`, 16, table entries; index 0 has highest priority
- `WAIT_W`, 4, wait-state counter width
- `TIMEOUT`, 64, cycles from decode to BERR on a miss; must be ≥1
- `IDX_W`, `$clog2(NUM_REGIONS)`, derived

Ports:
- `clk` in 1: system clock; the only clock
- `reset_n` in 1: asynchronous, active-low reset
- `cfg_we` in 1: write one table entry this cycle
- `cfg_idx` in IDX_W: entry written
- `cfg_base` in ADDR_W: window base
- `cfg_mask` in ADDR_W: compared bits (1 = compare)
- `cfg_wait` in WAIT_W: wait states before DTACK
- `cfg_rw_mode` in 2: 00 any, 01 read-only, 10 write-only, 11 disabled
- `m68k_a` in ADDR_W: CPU address
- `m68k_as_n` in 1: address strobe
- `m68k_rw` in 1: 1 = read
- `cs` out NUM_REGIONS: registered one-hot chip selects
- `hit` out 1: a region matched for the current cycle
- `hit_idx` out IDX_W: matched index
- `dtack_n` out 1: data acknowledge
- `berr_n` out 1: bus error
- `busy` out 1: FSM not in IDLE

## Operation
- Match for entry i: `(m68k_a & mask_i) == (base_i & mask_i)` and the rw qualifier holds. Mode 11 never matches.
- Among matching entries, the lowest index wins. `cs` contains at most one bit.
- Config writes update the table immediately, including during a bus cycle. A cycle already decoded keeps its latched `cs` and wait count.
- FSM states:
  - IDLE: `m68k_as_n` sampled low → DECODE.
  - DECODE: evaluate the table and register `cs`/`hit`/`hit_idx`.
    - Hit with wait 0 → ACK.
    - Hit with wait W>0 → WAIT, cnt=W.
    - Miss → TOUT, cnt=TIMEOUT.
  - WAIT: cnt decrements each cycle; when cnt==1 → ACK.
  - TOUT: cnt decrements each cycle; when cnt==1 → BERR.
  - ACK: `dtack_n`=0, held.
  - BERR: `berr_n`=0, held.
- `m68k_as_n` sampled high in any non-IDLE state → IDLE (completion or abort). At that edge `cs`, `hit`, `dtack_n`, `berr_n`, `busy` return to their idle values.
- A back-to-back strobe (as_n high for exactly one sample, then low) is decoded again from IDLE. Decoding never skips IDLE.
- Reset values:
  - Table: all entries mode 11, base 0, mask 0, wait 0.
  - Outputs: `cs`=0, `hit`=0, `hit_idx`=0, `dtack_n`=1, `berr_n`=1, `busy`=0.
  - FSM: IDLE.
- Reset asserted mid-cycle forces these values asynchronously.

## Timing
- Edge E0: IDLE samples `as_n`=0, moves to DECODE, `busy`=1.
- Edge E1: `cs`/`hit`/`hit_idx` valid.
- `dtack_n` falls at E(1+W) for wait W, so W=0 gives `dtack_n` low at E1 together with `cs`.
- Miss: `berr_n` falls at E(1+TIMEOUT).
- Address and rw are sampled only at the DECODE edge. Later changes are ignored until the next IDLE.
- `dtack_n` and `berr_n` are never low together.

## Structure
- Package `alpha68k_bus_pkg` holds:
  - rw-mode constants (`RW_ANY`, `RW_RD`, `RW_WR`, `RW_OFF`)
  - FSM state encoding (IDLE, DECODE, WAIT, TOUT, ACK, BERR)
  - default Alpha68k map constants used by the loader
- Sub-module `region_table`: the config register file plus the parallel comparators and priority encoder. It is combinational on reads and returns `match_vec`, `hit`, `idx`, `wait`.
- Top level contains the FSM, counter and output registers.

## Test plan
- Reset, then a read at 0x000100 with an empty table → `cs`=0, `berr_n` low at E(1+TIMEOUT)=E65, `dtack_n` stays 1; raising `as_n` → `berr_n`=1 and `busy`=0 at the next edge.
- Entry 0: base 0x000000, mask 0xFC0000, wait 0, mode 00. Read at 0x03FFFE → `cs`=0x0001, `hit_idx`=0, `dtack_n` low at E1.
- Entry 3: base 0x080000, mask 0xFFFFFE, mode 10, wait 2. A write to 0x080001 → `cs[3]` at E1, `dtack_n` at E3. A read to the same address → miss, BERR.
- Overlap: entry 1 = 0x040000/0xFFC000 and entry 5 = 0x040000/0xFF0000. Read at 0x040010 → `cs`=bit1 only. Read at 0x048000 → bit5 only.
- Abort: entry with wait 7, `as_n` raised at E3 → IDLE at E4, `dtack_n` never asserted, `cs` cleared at E4.
- Mid-cycle `cfg_we` disabling the active entry during WAIT → current cycle still DTACKs at E(1+W); the next access to that address → BERR.
